cnn_inference_core: RTL and testbench

- Single-kernel binary image classifier core: 28x28 8-bit image -> 3x3 valid convolution + ReLU (26x26) -> 2x2/stride-2 max pool (13x13) -> 2-class dense layer -> argmax prediction.
- Integrates the convolution sequencer, pooling layer and dense layer behind a start/done handshake.
- Sits below the system top level, which supplies packed image and weight vectors.

---
 rtl/cnn_inference_core.sv | 222 ++++++++++++++++++++++
 tb/tb_cnn_inference_core.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_inference_core.sv
// Single-kernel image classifier: 3x3 valid conv + ReLU, 2x2 max pool, 2-class dense, argmax.
// One MAC / read / feature per cycle behind a start/done handshake; latency is data-independent.
module cnn_inference_core #(
    parameter int IMG_W = 28,
    parameter int ACC_W = 32
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [IMG_W*IMG_W*8-1:0]             image_data_in_packed,
    input  logic [71:0]                          kernel_packed,
    input  logic [((IMG_W-2)/2)*((IMG_W-2)/2)*8-1:0] dense_w0_packed,
    input  logic [((IMG_W-2)/2)*((IMG_W-2)/2)*8-1:0] dense_w1_packed,
    output logic [ACC_W-1:0]                     class_0_score,
    output logic [ACC_W-1:0]                     class_1_score,
    output logic                                 prediction,
    output logic                                 done
);
    localparam int FM_W = IMG_W - 2;
    localparam int PM_W = FM_W / 2;
    localparam int FM_N = FM_W * FM_W;
    localparam int PM_N = PM_W * PM_W;
    localparam int CW   = $clog2(FM_W);
    localparam int PIXW = $clog2(IMG_W * IMG_W * 8);
    localparam int FMAW = $clog2(FM_N);
    localparam int PMAW = $clog2(PM_N);
    localparam int WBW  = $clog2(PM_N * 8);

    typedef enum logic [2:0] {S_IDLE, S_CONV, S_POOL, S_DENSE, S_PREDICT, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            row_q, row_d, col_q, col_d;
    logic [3:0]               step_q, step_d;
    logic [PMAW-1:0]          p_q, p_d;
    logic signed [23:0]       acc_q, acc_d;
    logic [15:0]              max_q, max_d;
    logic signed [ACC_W-1:0]  s0_q, s0_d, s1_q, s1_d;
    logic [ACC_W-1:0]         score0_q, score0_d, score1_q, score1_d;
    logic                     pred_q, pred_d, done_q, done_d;

    logic [15:0]              fm_mem [FM_N];
    logic [15:0]              pm_mem [PM_N];
    logic                     fm_we, pm_we;
    logic [FMAW-1:0]          fm_waddr, fm_raddr;
    logic [PMAW-1:0]          pm_waddr;
    logic [15:0]              fm_wdata, fm_rdata, pm_rdata;

    logic [1:0]               krow, kcol;
    logic [3:0]               kidx;
    logic [PIXW-1:0]          pix_bit;
    logic [WBW-1:0]           w_bit;
    logic [7:0]               pixel;
    logic signed [7:0]        kval, w0, w1;
    logic signed [16:0]       conv_prod;
    logic signed [23:0]       prod0, prod1;

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        step_d   = step_q;
        p_d      = p_q;
        acc_d    = acc_q;
        max_d    = max_q;
        s0_d     = s0_q;
        s1_d     = s1_q;
        score0_d = score0_q;
        score1_d = score1_q;
        pred_d   = pred_q;
        done_d   = done_q;
        fm_we    = 1'b0;
        pm_we    = 1'b0;

        case (step_q)
            4'd0: {krow, kcol} = {2'd0, 2'd0};
            4'd1: {krow, kcol} = {2'd0, 2'd1};
            4'd2: {krow, kcol} = {2'd0, 2'd2};
            4'd3: {krow, kcol} = {2'd1, 2'd0};
            4'd4: {krow, kcol} = {2'd1, 2'd1};
            4'd5: {krow, kcol} = {2'd1, 2'd2};
            4'd6: {krow, kcol} = {2'd2, 2'd0};
            4'd7: {krow, kcol} = {2'd2, 2'd1};
            4'd8: {krow, kcol} = {2'd2, 2'd2};
            default: {krow, kcol} = {2'd0, 2'd0};
        endcase
        kidx      = (step_q < 4'd9) ? step_q : 4'd0;
        pix_bit   = PIXW'(((int'(row_q) + int'(krow)) * IMG_W + int'(col_q) + int'(kcol)) * 8);
        pixel     = image_data_in_packed[pix_bit +: 8];
        kval      = $signed(kernel_packed[{kidx, 3'b000} +: 8]);
        conv_prod = $signed({1'b0, pixel}) * kval;

        // Pool window position comes from the low two step bits: {row offset, col offset}.
        fm_raddr = FMAW'((2 * int'(row_q) + int'(step_q[1])) * FM_W + 2 * int'(col_q) + int'(step_q[0]));
        fm_rdata = fm_mem[fm_raddr];
        fm_waddr = FMAW'(int'(row_q) * FM_W + int'(col_q));
        fm_wdata = acc_q[23] ? 16'd0 : ((acc_q > 24'sd32767) ? 16'h7FFF : acc_q[15:0]);
        pm_waddr = PMAW'(int'(row_q) * PM_W + int'(col_q));

        w_bit    = WBW'(int'(p_q) * 8);
        w0       = $signed(dense_w0_packed[w_bit +: 8]);
        w1       = $signed(dense_w1_packed[w_bit +: 8]);
        pm_rdata = pm_mem[p_q];
        prod0    = $signed(pm_rdata) * w0;
        prod1    = $signed(pm_rdata) * w1;

        case (state_q)
            S_IDLE: if (start) begin
                done_d  = 1'b0;
                row_d   = '0;
                col_d   = '0;
                step_d  = '0;
                p_d     = '0;
                acc_d   = '0;
                max_d   = '0;
                state_d = S_CONV;
            end
            S_CONV: if (step_q == 4'd9) begin
                fm_we  = 1'b1;
                acc_d  = '0;
                step_d = '0;
                if (col_q == CW'(FM_W - 1)) begin
                    col_d = '0;
                    if (row_q == CW'(FM_W - 1)) begin
                        row_d   = '0;
                        state_d = S_POOL;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end else begin
                acc_d  = acc_q + {{7{conv_prod[16]}}, conv_prod};
                step_d = step_q + 1'b1;
            end
            S_POOL: if (step_q == 4'd4) begin
                pm_we  = 1'b1;
                step_d = '0;
                if (col_q == CW'(PM_W - 1)) begin
                    col_d = '0;
                    if (row_q == CW'(PM_W - 1)) begin
                        row_d   = '0;
                        s0_d    = '0;
                        s1_d    = '0;
                        p_d     = '0;
                        state_d = S_DENSE;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end else begin
                max_d  = (step_q == 4'd0 || fm_rdata > max_q) ? fm_rdata : max_q;
                step_d = step_q + 1'b1;
            end
            S_DENSE: begin
                s0_d = s0_q + {{(ACC_W-24){prod0[23]}}, prod0};
                s1_d = s1_q + {{(ACC_W-24){prod1[23]}}, prod1};
                if (p_q == PMAW'(PM_N - 1)) begin
                    p_d     = '0;
                    state_d = S_PREDICT;
                end else begin
                    p_d = p_q + 1'b1;
                end
            end
            S_PREDICT: begin
                score0_d = s0_q;
                score1_d = s1_q;
                pred_d   = (s0_q > s1_q) ? 1'b0 : 1'b1;
                state_d  = S_DONE;
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            col_q    <= '0;
            step_q   <= '0;
            p_q      <= '0;
            acc_q    <= '0;
            max_q    <= '0;
            s0_q     <= '0;
            s1_q     <= '0;
            score0_q <= '0;
            score1_q <= '0;
            pred_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            step_q   <= step_d;
            p_q      <= p_d;
            acc_q    <= acc_d;
            max_q    <= max_d;
            s0_q     <= s0_d;
            s1_q     <= s1_d;
            score0_q <= score0_d;
            score1_q <= score1_d;
            pred_q   <= pred_d;
            done_q   <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fm_we) fm_mem[fm_waddr] <= fm_wdata;
        if (pm_we) pm_mem[pm_waddr] <= max_q;
    end

    assign class_0_score = score0_q;
    assign class_1_score = score1_q;
    assign prediction    = pred_q;
    assign done          = done_q;
endmodule

// File: tb/tb_cnn_inference_core.sv
// Scoreboard bench for cnn_inference_core: expected results queued at start, checked at done.
module tb_cnn_inference_core;
    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [6271:0] img;
    logic [71:0]   ker;
    logic [1351:0] w0;
    logic [1351:0] w1;
    logic [31:0]   class_0_score;
    logic [31:0]   class_1_score;
    logic          prediction;
    logic          done;

    typedef struct {
        int s0;
        int s1;
        int pred;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   first_lat = -1;

    cnn_inference_core #(.IMG_W(28), .ACC_W(32)) dut (
        .clk                  (clk),
        .reset                (reset),
        .start                (start),
        .image_data_in_packed (img),
        .kernel_packed        (ker),
        .dense_w0_packed      (w0),
        .dense_w1_packed      (w1),
        .class_0_score        (class_0_score),
        .class_1_score        (class_1_score),
        .prediction           (prediction),
        .done                 (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model();
        exp_t e;
        int fm[676];
        int pm[169];
        int acc, m, v;
        for (int r = 0; r < 26; r++)
            for (int c = 0; c < 26; c++) begin
                acc = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        acc += int'(img[((r+i)*28 + c+j)*8 +: 8]) * int'($signed(ker[(i*3+j)*8 +: 8]));
                fm[r*26+c] = (acc < 0) ? 0 : ((acc > 32767) ? 32767 : acc);
            end
        for (int r = 0; r < 13; r++)
            for (int c = 0; c < 13; c++) begin
                m = 0;
                for (int d = 0; d < 4; d++) begin
                    v = fm[(2*r + d/2)*26 + 2*c + d%2];
                    if (v > m) m = v;
                end
                pm[r*13+c] = m;
            end
        e.s0 = 0;
        e.s1 = 0;
        for (int p = 0; p < 169; p++) begin
            e.s0 += pm[p] * int'($signed(w0[p*8 +: 8]));
            e.s1 += pm[p] * int'($signed(w1[p*8 +: 8]));
        end
        e.pred = (e.s0 > e.s1) ? 0 : 1;
        return e;
    endfunction

    function automatic exp_t mk(input int s0, input int s1, input int pred);
        exp_t e;
        e.s0 = s0;
        e.s1 = s1;
        e.pred = pred;
        return e;
    endfunction

    task automatic fill(input int iv, input int kv, input int w0v, input int w1v);
        for (int n = 0; n < 784; n++) img[n*8 +: 8] = 8'(iv);
        for (int n = 0; n < 9; n++) ker[n*8 +: 8] = 8'(kv);
        for (int n = 0; n < 169; n++) begin
            w0[n*8 +: 8] = 8'(w0v);
            w1[n*8 +: 8] = 8'(w1v);
        end
    endtask

    // Counts edges after the accept edge until done is seen; optionally pulses start mid-run.
    task automatic wait_done(input string tag, input bit busy, output int cyc);
        exp_t e;
        cyc = 0;
        while (cyc < 10000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (busy) start = (cyc == 1000 || cyc == 5000);
            if (done) break;
        end
        check_val({tag, "_done"}, int'(done), 1);
        if (sb_q.size() == 0) begin
            check_val({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = sb_q.pop_front();
            check_val({tag, "_s0"}, int'(class_0_score), e.s0);
            check_val({tag, "_s1"}, int'(class_1_score), e.s1);
            check_val({tag, "_pred"}, int'(prediction), e.pred);
        end
        if (first_lat < 0) begin
            first_lat = cyc;
            check_val({tag, "_lat_bound"}, int'(cyc >= 7774 && cyc <= 7800), 1);
        end else begin
            check_val({tag, "_latency"}, cyc, first_lat);
        end
    endtask

    task automatic run(input string tag, input exp_t e, input bit busy);
        int cyc;
        @(negedge clk);
        start = 1'b1;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        check_val({tag, "_done_drop"}, int'(done), 0);
        wait_done(tag, busy, cyc);
    endtask

    initial begin
        int   cyc;
        exp_t e;
        reset = 1'b1;
        start = 1'b1;
        fill(1, 1, 1, 0);
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_done", int'(done), 0);
        check_val("rst_pred", int'(prediction), 0);
        check_val("rst_s0", int'(class_0_score), 0);
        check_val("rst_s1", int'(class_1_score), 0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_val("rst_start_ignored", int'(done), 0);

        fill(0, 5, -3, 7);
        run("zero", mk(0, 0, 1), 1'b0);
        repeat (30) @(posedge clk);
        #1;
        check_val("zero_hold_done", int'(done), 1);
        check_val("zero_hold_pred", int'(prediction), 1);

        fill(1, 1, 1, 0);
        run("ones", mk(1521, 0, 0), 1'b0);

        fill(10, -1, 1, 1);
        run("relu", mk(0, 0, 1), 1'b0);

        fill(0, 0, 1, 0);
        img[7:0] = 8'd100;
        ker[7:0] = 8'd2;
        w1[7:0]  = 8'd3;
        run("single", mk(200, 600, 1), 1'b0);

        fill(255, 127, 0, 0);
        w0[7:0] = 8'd1;
        run("sat_busy", mk(32767, 0, 0), 1'b1);

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (500) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_val("abort_done", int'(done), 0);
        check_val("abort_s0", int'(class_0_score), 0);
        @(negedge clk);
        reset = 1'b0;
        run("after_abort", mk(32767, 0, 0), 1'b0);

        for (int n = 0; n < 784; n++) img[n*8 +: 8] = 8'($urandom_range(0, 255));
        for (int n = 0; n < 9; n++) ker[n*8 +: 8] = 8'($urandom_range(0, 255));
        for (int n = 0; n < 169; n++) begin
            w0[n*8 +: 8] = 8'($urandom_range(0, 255));
            w1[n*8 +: 8] = 8'($urandom_range(0, 255));
        end
        e = model();
        run("random", e, 1'b0);

        fill(1, 1, 1, 0);
        @(negedge clk);
        start = 1'b1;
        sb_q.push_back(mk(1521, 0, 0));
        @(posedge clk);
        #1;
        wait_done("b2b_first", 1'b0, cyc);
        sb_q.push_back(mk(1521, 0, 0));
        @(posedge clk);
        #1;
        check_val("b2b_retrigger", int'(done), 0);
        start = 1'b0;
        wait_done("b2b_second", 1'b0, cyc);

        check_val("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
